// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline control-field layout, per-boundary widths and stage-register state encoding
package cpu_pkg;
  localparam int CTRL_MEM_WR = 0;
  localparam int CTRL_MEM_EN = 1;
  localparam int CTRL_WR_EN = 2;
  localparam int CTRL_WR_REG = 3;
  localparam int CTRL_WR_REG_W = 5;
  localparam int CTRL_HALT = 8;
  localparam int IFID_DATA_W = 64;
  localparam int IFID_CTRL_W = 16;
  localparam int IDEX_DATA_W = 64;
  localparam int IDEX_CTRL_W = 16;
  localparam int EXMEM_DATA_W = 64;
  localparam int EXMEM_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 16;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE = 2'd1;
  localparam logic [1:0] ST_TWO = 2'd2;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: data+ctrl register with load enable; clr zeroes ctrl only
module pipe_entry #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [CTRL_W-1:0] c_in,
  output logic [DATA_W-1:0] d,
  output logic [CTRL_W-1:0] c
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      d <= '0;
      c <= '0;
    end else begin
      if (ld) d <= d_in;
      if (clr) c <= '0;
      else if (ld) c <= c_in;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, bubble ctrl zeroing and optional skid entry
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic              err
);
  logic push, pop, main_ld;
  logic [DATA_W-1:0] main_d_in;
  logic [CTRL_W-1:0] main_c_in, main_c;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_ctrl = out_valid ? main_c : '0;
  assign err = $isunknown({in_valid, in_ctrl, flush, out_ready});
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk(clk), .rst(rst), .ld(main_ld), .clr(flush),
    .d_in(main_d_in), .c_in(main_c_in), .d(out_data), .c(main_c)
  );
  if (SKID != 0) begin : g_skid
    logic [1:0] state;
    logic skid_ld;
    logic [DATA_W-1:0] skid_d;
    logic [CTRL_W-1:0] skid_c;
    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk(clk), .rst(rst), .ld(skid_ld), .clr(flush),
      .d_in(in_data), .c_in(in_ctrl), .d(skid_d), .c(skid_c)
    );
    always_ff @(posedge clk or negedge rst)
      if (!rst) state <= ST_EMPTY;
      else if (flush) state <= ST_EMPTY;
      else if (state == ST_EMPTY) state <= push ? ST_ONE : ST_EMPTY;
      else if (state == ST_ONE) state <= (push && !pop) ? ST_TWO : (!push && pop) ? ST_EMPTY : ST_ONE;
      else state <= pop ? ST_ONE : ST_TWO;
    assign in_ready = state != ST_TWO;
    assign out_valid = state != ST_EMPTY;
    assign occupancy = state;
    assign main_ld = !flush && (state == ST_EMPTY ? push : state == ST_ONE ? push && pop : pop);
    assign skid_ld = !flush && state == ST_ONE && push && !pop;
    assign main_d_in = state == ST_TWO ? skid_d : in_data;
    assign main_c_in = state == ST_TWO ? skid_c : in_ctrl;
  end else begin : g_single
    logic valid;
    always_ff @(posedge clk or negedge rst)
      if (!rst) valid <= 1'b0;
      else valid <= flush ? 1'b0 : push ? 1'b1 : pop ? 1'b0 : valid;
    assign in_ready = !valid | out_ready;
    assign out_valid = valid;
    assign occupancy = {1'b0, valid};
    assign main_ld = push && !flush;
    assign main_d_in = in_data;
    assign main_c_in = in_ctrl;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and scoreboard checks of pipe_stage_reg with SKID=1 and SKID=0
module tb_pipe_stage_reg;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [63:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic in_ready, out_valid, err, in_ready0, out_valid0, err0;
  logic [63:0] out_data, out_data0;
  logic [15:0] out_ctrl, out_ctrl0;
  logic [1:0] occupancy, occupancy0;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy), .err(err)
  );
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occupancy0), .err(err0)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_ctrl !== 16'h0) begin fails++; $display("FAIL reset_ctrl got %h exp 0000", out_ctrl); end
    checks++; if (out_data !== 64'h0) begin fails++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    #10 rst = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask
  task automatic test_basic;
    in_valid = 1'b1; in_data = 64'h0000_0000_0000_1234; in_ctrl = 16'h0081; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 64'h1234) begin fails++; $display("FAIL basic_data got %h exp 1234", out_data); end
    checks++; if (out_ctrl !== 16'h0081) begin fails++; $display("FAIL basic_ctrl got %h exp 0081", out_ctrl); end
    checks++; if (occupancy !== 2'd1) begin fails++; $display("FAIL basic_occ got %0d exp 1", occupancy); end
    tick;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain_valid got %0b exp 0", out_valid); end
    checks++; if (out_ctrl !== 16'h0) begin fails++; $display("FAIL basic_bubble_ctrl got %h exp 0000", out_ctrl); end
    out_ready = 1'b0;
  endtask
  task automatic test_skid;
    in_valid = 1'b1; in_data = 64'hA; in_ctrl = 16'h00A1;
    tick;
    out_ready = 1'b0; in_data = 64'hB; in_ctrl = 16'h00B2;
    tick;
    in_data = 64'hC; in_ctrl = 16'h00C3;
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL skid_occ got %0d exp 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL skid_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_data !== 64'hA) begin fails++; $display("FAIL skid_hold_a got %h exp a", out_data); end
    tick;
    checks++; if (out_data !== 64'hA || out_ctrl !== 16'h00A1 || occupancy !== 2'd2) begin fails++; $display("FAIL skid_stall got %h/%h/%0d exp a/00a1/2", out_data, out_ctrl, occupancy); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_data !== 64'hB || out_ctrl !== 16'h00B2 || occupancy !== 2'd1) begin fails++; $display("FAIL skid_out_b got %h/%h/%0d exp b/00b2/1", out_data, out_ctrl, occupancy); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL skid_ready_back got %0b exp 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hC || out_ctrl !== 16'h00C3) begin fails++; $display("FAIL skid_out_c got %0b/%h/%h exp 1/c/00c3", out_valid, out_data, out_ctrl); end
    tick;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++; $display("FAIL skid_no_dup got %0b/%0d exp 0/0", out_valid, occupancy); end
    out_ready = 1'b0;
  endtask
  task automatic test_flush;
    in_valid = 1'b1; in_data = 64'hE; in_ctrl = 16'h00E1;
    tick;
    in_data = 64'hF; in_ctrl = 16'h00F2;
    tick;
    in_data = 64'hD; in_ctrl = 16'h00D4; flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin fails++; $display("FAIL flush_out got %0b/%h exp 0/0000", out_valid, out_ctrl); end
    checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_state got occ %0d rdy %0b exp 0/1", occupancy, in_ready); end
    tick;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_d_gone got %0b exp 0", out_valid); end
    in_valid = 1'b1; flush = 1'b1;
    tick;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++; $display("FAIL flush_drop_ready got %0b/%0d exp 0/0", out_valid, occupancy); end
  endtask
  task automatic test_async_reset;
    in_valid = 1'b1; in_data = 64'h11; in_ctrl = 16'h0011;
    tick;
    in_data = 64'h22; in_ctrl = 16'h0022;
    tick;
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL arst_fill got %0d exp 2", occupancy); end
    #3 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || occupancy !== 2'd0) begin fails++; $display("FAIL arst_immediate got %0b/%h/%0d exp 0/0000/0", out_valid, out_ctrl, occupancy); end
    #2 rst = 1'b1;
    in_valid = 1'b1; in_data = 64'h33; in_ctrl = 16'h0033;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h33 || occupancy !== 2'd1) begin fails++; $display("FAIL arst_first_push got %0b/%h/%0d exp 1/33/1", out_valid, out_data, occupancy); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL arst_drain got %0d exp 0", occupancy); end
  endtask
  task automatic test_random;
    logic [79:0] q[$];
    logic [79:0] pay;
    logic m_push, m_pop;
    int sent = 0, got = 0, cyc = 0;
    pay = {32'($urandom), 32'($urandom), 16'($urandom)};
    while (got < 100 && cyc < 1000) begin
      in_valid = sent < 100;
      {in_data, in_ctrl} = pay;
      out_ready = (cyc % 2) == 0;
      m_push = in_valid && q.size() < 2;
      m_pop = q.size() > 0 && out_ready;
      tick;
      if (m_pop) begin void'(q.pop_front()); got++; end
      if (m_push) begin q.push_back(pay); sent++; pay = {32'($urandom), 32'($urandom), 16'($urandom)}; end
      checks++; if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", cyc, out_valid, q.size() > 0); end
      checks++; if (occupancy !== 2'(q.size())) begin fails++; $display("FAIL rand_occ cyc %0d got %0d exp %0d", cyc, occupancy, q.size()); end
      checks++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_ready cyc %0d got %0b exp %0b", cyc, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if ({out_data, out_ctrl} !== q[0]) begin fails++; $display("FAIL rand_payload cyc %0d got %h exp %h", cyc, {out_data, out_ctrl}, q[0]); end
      end else begin
        checks++; if (out_ctrl !== 16'h0) begin fails++; $display("FAIL rand_bubble cyc %0d got %h exp 0000", cyc, out_ctrl); end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 100) begin fails++; $display("FAIL rand_timeout got %0d items exp 100", got); end
  endtask
  task automatic test_no_skid;
    in_valid0 = 1'b1; in_data = 64'h55; in_ctrl = 16'h0055; out_ready0 = 1'b0;
    tick;
    in_data = 64'h66; in_ctrl = 16'h0066;
    checks++; if (out_valid0 !== 1'b1 || out_data0 !== 64'h55 || occupancy0 !== 2'd1) begin fails++; $display("FAIL ns_load got %0b/%h/%0d exp 1/55/1", out_valid0, out_data0, occupancy0); end
    checks++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL ns_stall_ready got %0b exp 0", in_ready0); end
    out_ready0 = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL ns_comb_ready got %0b exp 1", in_ready0); end
    tick;
    in_valid0 = 1'b0;
    checks++; if (out_data0 !== 64'h66 || out_ctrl0 !== 16'h0066 || occupancy0 !== 2'd1) begin fails++; $display("FAIL ns_replace got %h/%h/%0d exp 66/0066/1", out_data0, out_ctrl0, occupancy0); end
    tick;
    out_ready0 = 1'b0;
    checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== 16'h0 || occupancy0 !== 2'd0) begin fails++; $display("FAIL ns_drain got %0b/%h/%0d exp 0/0000/0", out_valid0, out_ctrl0, occupancy0); end
  endtask
  task automatic test_err;
    logic exp_err;
    in_ctrl = 16'hxxxx;
    exp_err = $isunknown(in_ctrl);
    #1;
    checks++; if (err !== exp_err) begin fails++; $display("FAIL err_unknown got %0b exp %0b", err, exp_err); end
    in_ctrl = 16'h00ff;
    #1;
    checks++; if (err !== 1'b0 || err0 !== 1'b0) begin fails++; $display("FAIL err_known got %0b/%0b exp 0/0", err, err0); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_skid;
    test_flush;
    test_async_reset;
    test_random;
    test_no_skid;
    test_err;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the successor to the fixed per-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a datapath payload and a control payload across one stage boundary using a valid/ready handshake.
- Supports stall via backpressure, synchronous flush for branch squash, and bubble insertion with the control payload forced to zero.
- An optional skid entry registers the ready path so that stalls do not create a combinational chain through the pipeline.

Parameters:
- DATA_W, 64: width of the datapath payload (PC_inc, operands, ALU result, immediates, ...). Not cleared on flush.
- CTRL_W, 16: width of the control payload (mem_wr, mem_en, wr_en, wr_reg, halt, ...). Reads as zero whenever the stage holds a bubble.
- SKID, 1: 0 selects a single entry with combinational in_ready; 1 selects two entries (main + skid) with registered in_ready.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: upstream stage presents a valid instruction.
- in_ready, output, 1: this stage accepts a transfer this cycle.
- in_data, input, DATA_W: datapath payload from upstream.
- in_ctrl, input, CTRL_W: control payload from upstream.
- flush, input, 1: squash all held and incoming instructions.
- out_valid, output, 1: held instruction presented downstream.
- out_ready, input, 1: downstream accepts; low means stall.
- out_data, output, DATA_W: datapath payload to downstream.
- out_ctrl, output, CTRL_W: control payload to downstream; forced to 0 when out_valid=0.
- occupancy, output, 2: number of entries held (0..2; never exceeds 1 when SKID=0).
- err, output, 1: combinational; 1 if any bit of {in_valid, in_ctrl, flush, out_ready} is X or Z, otherwise 0.

Behaviour:
- Handshake definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (rst low, asynchronous):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - Skid entry cleared.
  - in_ready=1 once rst deasserts (SKID=1); in_ready combinational per the rule below (SKID=0).
  - Reset asserted mid-transfer discards all entries.
- Latency: an accepted input appears on out_* on the edge after push. There is no same-cycle bypass.
- SKID=0:
  - in_ready = !out_valid | out_ready.
  - On push, main <= in.
  - On pop without push, out_valid <= 0.
- SKID=1, state machine EMPTY / ONE / TWO; in_ready = (state != TWO), registered:
  - EMPTY: push -> ONE, main <= in.
  - ONE, push & pop -> ONE, main <= in.
  - ONE, push & !pop -> TWO, skid <= in; main holds.
  - ONE, !push & pop -> EMPTY.
  - ONE, neither -> ONE, hold.
  - TWO: no push is possible. pop -> ONE, main <= skid. Otherwise hold.
- Ordering: strictly FIFO; the main entry is always older than the skid entry.
- Stall: with out_ready=0, out_valid, out_data and out_ctrl are held stable until pop.
- Flush (synchronous):
  - On the edge, state -> EMPTY (SKID=1) or out_valid -> 0 (SKID=0); stored ctrl is zeroed and occupancy -> 0.
  - An input presented in the same cycle is dropped even if in_ready=1.
  - Flush overrides push and pop. A pop coinciding with flush still counts as transferred downstream (downstream has sampled it).
- Bubble: out_valid=0 implies out_ctrl=0 combinationally. out_data may hold stale values; consumers must not qualify on out_data.
- Data registers load only on their load condition. Control registers additionally clear on flush.
- occupancy: EMPTY=0, ONE=1, TWO=2.

Decomposition:
- Shared package cpu_pkg:
  - Stage control-field widths and offsets (CTRL_MEM_WR, CTRL_MEM_EN, CTRL_WR_EN, CTRL_WR_REG, CTRL_HALT, ...).
  - Per-boundary DATA_W/CTRL_W constants (IFID_*, IDEX_*, EXMEM_*, MEMWB_*).
  - State encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
- One sub-module, pipe_entry: a DATA_W+CTRL_W register with load enable and ctrl-clear. Instantiated as main and skid.

Test Plan:
- Reset, then in_valid=1, in_data=64'h0000_0000_0000_1234, in_ctrl=16'h0081, out_ready=1 -> next edge: out_valid=1, out_data=...1234, out_ctrl=16'h0081, occupancy=1.
- SKID=1, stream A,B,C with out_ready=0 from the cycle after A -> A held on out_*; B goes to skid; occupancy=2; in_ready=0; C is not accepted. Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- flush=1 while state=TWO and in_valid=1 (D) -> next edge: out_valid=0, out_ctrl=16'h0000, occupancy=0, in_ready=1, and D never appears on the output.
- out_ready toggling 1,0,1,0 with continuous in_valid over 100 random payloads -> scoreboard matches in order; out_ctrl==0 whenever out_valid==0.
- rst asserted asynchronously mid-cycle with occupancy=2 -> out_valid=0 and out_ctrl=0 immediately, without waiting for clk; after release, first push behaves as from EMPTY.
- SKID=0, out_valid=1 and out_ready=0 -> in_ready=0. Set out_ready=1 in the same cycle -> in_ready=1 combinationally, and push & pop replace main.
- Drive in_ctrl=16'hxxxx -> err=1; drive in_ctrl to known values -> err=0.
